// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the CONV engine stream controllers.
//   state_t      : sequencer state (IDLE / ISSUE / DRAIN / DONE)
//   AW_DEF       : default address width (also the pass-length width)
//   PW_DEF       : default pass-count width
//   MAX_OUT_DEF  : default limit on outstanding address beats
//   CNT_W        : width of the outstanding-beat counter (limit is 1..15)
// -----------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned AW_DEF      = 11;
  localparam int unsigned PW_DEF      = 8;
  localparam int unsigned MAX_OUT_DEF = 4;

  // Four bits hold any limit up to 15 outstanding beats.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/wfc_credit.sv
// -----------------------------------------------------------------------------
// wfc_credit
// Up/down counter of outstanding request beats with a limit compare.
//   clk, rst    : clock, synchronous active-high reset (clears all credits)
//   inc         : a request beat was accepted this cycle
//   dec         : a response beat was accepted this cycle
//   avail_next  : the count after this edge will be below LIMIT
//   underflow   : dec seen while the count is already zero (dec is ignored)
// -----------------------------------------------------------------------------
module wfc_credit
  import conv_pkg::*;
#(
  parameter int unsigned LIMIT = MAX_OUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic avail_next,
  output logic underflow
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             dec_ok;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    underflow = dec && (cnt == '0);
    dec_ok    = dec && !underflow;
    cnt_next  = cnt;
    if (inc && !dec_ok) begin
      cnt_next = cnt + CNT_W'(1);
    end else if (!inc && dec_ok) begin
      cnt_next = cnt - CNT_W'(1);
    end
    // Looking at the next count lets the owner register its valid flag
    // and still re-assert it the cycle after a credit is returned.
    avail_next = (cnt_next < CNT_W'(LIMIT));
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// weight_fetch_ctrl
// Weight-fetch sequencer: on start, issues cfg_pass passes of cfg_len
// consecutive addresses from cfg_base, marks first/last beat of each pass,
// throttles by outstanding credits and snoops the returned data stream to
// signal completion of the final pass.
//   clk, rst                       : clock, synchronous active-high reset
//   start, cfg_base/len/pass       : job request and configuration
//   busy, done, err                : status (err is sticky until rst)
//   addr, addr_first, addr_last    : address beat payload
//   addr_valid / addr_ready        : address handshake
//   mon_valid, mon_ready, mon_last : snooped data-stream handshake
//   last_for_weight_ctrl           : pulse when the final data pass completes
// -----------------------------------------------------------------------------
module weight_fetch_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned PW      = PW_DEF,
  parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW-1:0] cfg_len,
  input  logic [PW-1:0] cfg_pass,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] addr,
  output logic          addr_first,
  output logic          addr_last,
  output logic          addr_valid,
  input  logic          addr_ready,
  input  logic          mon_valid,
  input  logic          mon_ready,
  input  logic          mon_last,
  output logic          last_for_weight_ctrl
);

  state_t        state;
  logic [AW-1:0] base_q, len_q, offset_q, offset_nx;
  logic [PW-1:0] npass_q, pass_q, pass_nx, rx_pass_q;
  logic          addr_acc, mon_acc, end_of_pass, final_addr, final_data;
  logic          avail_next, underflow;

  assign addr_acc    = addr_valid && addr_ready;
  assign mon_acc     = mon_valid && mon_ready;
  assign end_of_pass = (offset_q == len_q - AW'(1));
  assign final_addr  = addr_acc && end_of_pass && (pass_q == npass_q - PW'(1));
  assign final_data  = mon_acc && mon_last && (rx_pass_q == npass_q - PW'(1));

  wfc_credit #(.LIMIT(MAX_OUT)) u_credit (
    .clk        (clk),
    .rst        (rst),
    .inc        (addr_acc),
    .dec        (mon_acc),
    .avail_next (avail_next),
    .underflow  (underflow)
  );

  // Offset/pass position after this edge; the address registers are loaded
  // from it so the beat on the bus always matches the counters.
  always_comb begin
    offset_nx = offset_q;
    pass_nx   = pass_q;
    if (addr_acc) begin
      if (end_of_pass) begin
        offset_nx = '0;
        pass_nx   = pass_q + PW'(1);
      end else begin
        offset_nx = offset_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      base_q               <= '0;
      len_q                <= '0;
      npass_q              <= '0;
      offset_q             <= '0;
      pass_q               <= '0;
      rx_pass_q            <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      err                  <= 1'b0;
      addr                 <= '0;
      addr_first           <= 1'b0;
      addr_last            <= 1'b0;
      addr_valid           <= 1'b0;
      last_for_weight_ctrl <= 1'b0;
    end else begin
      done                 <= 1'b0;
      last_for_weight_ctrl <= 1'b0;

      // Data beats are only legal while a job has addresses in flight.
      if (underflow || (mon_acc && (state == IDLE || state == DONE))) begin
        err <= 1'b1;
      end
      if (mon_acc && mon_last && (state == ISSUE || state == DRAIN)) begin
        rx_pass_q <= rx_pass_q + PW'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (cfg_len == '0 || cfg_pass == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= ISSUE;
              base_q     <= cfg_base;
              len_q      <= cfg_len;
              npass_q    <= cfg_pass;
              offset_q   <= '0;
              pass_q     <= '0;
              rx_pass_q  <= '0;
              addr       <= cfg_base;
              addr_first <= 1'b1;
              addr_last  <= (cfg_len == AW'(1));
              addr_valid <= avail_next;
            end
          end
        end

        ISSUE: begin
          // The final data beat cannot precede the final address beat.
          if (final_data) begin
            err <= 1'b1;
          end
          offset_q   <= offset_nx;
          pass_q     <= pass_nx;
          addr       <= base_q + offset_nx;
          addr_first <= (offset_nx == '0);
          addr_last  <= (offset_nx == len_q - AW'(1));
          if (final_addr) begin
            state      <= DRAIN;
            addr_valid <= 1'b0;
          end else begin
            addr_valid <= avail_next;
          end
        end

        DRAIN: begin
          if (final_data) begin
            state                <= DONE;
            done                 <= 1'b1;
            last_for_weight_ctrl <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_fetch_ctrl
// Directed and randomized stimulus for weight_fetch_ctrl. The reference model
// expands each accepted job into its full list of expected address beats and
// tracks outstanding beats, received pass-ends and the job status flags.
// -----------------------------------------------------------------------------
module tb_weight_fetch_ctrl;
  import conv_pkg::*;

  localparam int AW      = 11;
  localparam int PW      = 8;
  localparam int MAX_OUT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_len = '0;
  logic [PW-1:0] cfg_pass = '0;
  logic          busy, done, err;
  logic [AW-1:0] addr;
  logic          addr_first, addr_last, addr_valid;
  logic          addr_ready = 1'b0;
  logic          mon_valid = 1'b0;
  logic          mon_ready = 1'b0;
  logic          mon_last = 1'b0;
  logic          last_for_weight_ctrl;

  always #5 clk = ~clk;

  weight_fetch_ctrl #(.AW(AW), .PW(PW), .MAX_OUT(MAX_OUT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .cfg_base             (cfg_base),
    .cfg_len              (cfg_len),
    .cfg_pass             (cfg_pass),
    .busy                 (busy),
    .done                 (done),
    .err                  (err),
    .addr                 (addr),
    .addr_first           (addr_first),
    .addr_last            (addr_last),
    .addr_valid           (addr_valid),
    .addr_ready           (addr_ready),
    .mon_valid            (mon_valid),
    .mon_ready            (mon_ready),
    .mon_last             (mon_last),
    .last_for_weight_ctrl (last_for_weight_ctrl)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic          f;
    logic          l;
  } beat_t;

  // Reference model state
  beat_t exp_q[$];     // address beats still to be issued for the current job
  logic  pend_q[$];    // last flags of data beats the responder still owes
  int    out_model;
  bit    active;
  bit    exp_done, exp_lastw, exp_err;
  int    rx_last, npass_m;
  bit    model_ok;

  // Responder / stimulus controls
  bit    mon_en;
  int    mon_budget;
  bit    stray;
  int    ready_pct, mon_pct;
  bit    drv_addr_acc, drv_mon_acc;
  bit    prev_stall;
  logic [AW-1:0] prev_addr;
  logic  prev_f, prev_l;
  int    beats_acc;

  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = active && (exp_q.size() > 0) && (out_model < MAX_OUT);
    check("busy", busy, active || exp_done);
    check("done", done, exp_done);
    check("last_for_weight_ctrl", last_for_weight_ctrl, exp_lastw);
    check("err", err, exp_err);
    check("addr_valid", addr_valid, exp_valid);
    if (prev_stall) begin
      check("stall_addr", addr, prev_addr);
      check("stall_first", addr_first, prev_f);
      check("stall_last", addr_last, prev_l);
    end
  endtask

  task automatic drive(input bit st, input bit rs);
    rst        = rs;
    start      = st;
    addr_ready = ($urandom_range(99) < ready_pct);
    if (stray) begin
      mon_valid = 1'b1;
      mon_ready = 1'b1;
      mon_last  = 1'b0;
    end else begin
      mon_valid = mon_en && (pend_q.size() > 0) && (mon_budget != 0) &&
                  ($urandom_range(99) < mon_pct);
      mon_ready = 1'b1;
      mon_last  = 1'b0;
      if (mon_valid) mon_last = pend_q[0];
    end
    drv_addr_acc = !rs && (addr_valid === 1'b1) && addr_ready;
    drv_mon_acc  = !rs && mon_valid && mon_ready;
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_q.delete();
    out_model  = 0;
    active     = 0;
    exp_done   = 0;
    exp_lastw  = 0;
    exp_err    = 0;
    rx_last    = 0;
    npass_m    = 0;
    prev_stall = 0;
    model_ok   = 1;
  endtask

  task automatic model_update(input bit st);
    bit    idle, nd, nl, uf;
    beat_t e;
    beat_t b;
    idle = !active && !exp_done;
    nd   = 0;
    nl   = 0;
    if (drv_addr_acc && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pend_q.push_back(e.l);
      beats_acc++;
    end
    uf = drv_mon_acc && (out_model == 0);
    out_model = out_model + int'(drv_addr_acc) - int'(drv_mon_acc && !uf);
    if (drv_mon_acc) begin
      if (!stray && pend_q.size() > 0) void'(pend_q.pop_front());
      if (mon_budget > 0) mon_budget--;
      if (!active || uf) exp_err = 1;
      if (active && mon_last) begin
        rx_last++;
        if (rx_last == npass_m) begin
          if (exp_q.size() > 0) exp_err = 1;
          else begin
            nd = 1;
            nl = 1;
            active = 0;
          end
        end
      end
    end
    if (st && idle) begin
      if (cfg_len == '0 || cfg_pass == '0) begin
        nd = 1;
      end else begin
        active  = 1;
        rx_last = 0;
        npass_m = int'(cfg_pass);
        for (int p = 0; p < int'(cfg_pass); p++) begin
          for (int o = 0; o < int'(cfg_len); o++) begin
            b.a = cfg_base + o[AW-1:0];
            b.f = (o == 0);
            b.l = (o == int'(cfg_len) - 1);
            exp_q.push_back(b);
          end
        end
      end
    end
    exp_done  = nd;
    exp_lastw = nl;
  endtask

  task automatic cycle(input bit st = 1'b0, input bit rs = 1'b0);
    beat_t e;
    @(negedge clk);
    if (model_ok) check_outputs();
    drive(st, rs);
    prev_stall = !rs && (addr_valid === 1'b1) && !addr_ready;
    prev_addr  = addr;
    prev_f     = addr_first;
    prev_l     = addr_last;
    if (drv_addr_acc) begin
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("addr", addr, e.a);
        check("addr_first", addr_first, e.f);
        check("addr_last", addr_last, e.l);
      end else begin
        check("spurious_beat", addr_valid, 1'b0);
      end
    end
    @(posedge clk);
    if (rs) model_reset();
    else    model_update(st);
  endtask

  task automatic run_to_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((active || exp_done) && n < max_cycles) begin
      cycle();
      n++;
    end
    check({tag, "_timeout"}, active || exp_done, 1'b0);
    cycle();
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] l,
                           input logic [PW-1:0] p);
    @(negedge clk);
    cfg_base = b;
    cfg_len  = l;
    cfg_pass = p;
    beats_acc = 0;
    cycle(1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    #2;
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_valid"}, addr_valid, 1'b0);
    check({tag, "_addr"}, addr, '0);
    check({tag, "_first"}, addr_first, 1'b0);
    check({tag, "_last"}, addr_last, 1'b0);
    check({tag, "_lastw"}, last_for_weight_ctrl, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_ok   = 0;
    mon_en     = 1;
    mon_budget = -1;
    stray      = 0;
    ready_pct  = 100;
    mon_pct    = 100;
    prev_stall = 0;

    // Reset state
    cycle(1'b0, 1'b1);
    check_reset_values("reset");
    cycle();

    // Two passes of three, data returning one cycle after each address
    start_job(11'h010, 11'd3, 8'd2);
    run_to_idle("base_pass2", 100);
    check("base_pass2_beats", beats_acc, 6);

    // Address wrap at the top of the address space
    start_job(11'h7FE, 11'd4, 8'd1);
    run_to_idle("wrap", 100);
    check("wrap_beats", beats_acc, 4);

    // Credit limit: no data returns, exactly MAX_OUT beats go out
    mon_en = 0;
    start_job(11'h040, 11'd8, 8'd1);
    for (int i = 0; i < 10; i++) cycle();
    check("credit_beats", beats_acc, MAX_OUT);
    #2 check("credit_blocked", addr_valid, 1'b0);
    mon_en     = 1;
    mon_budget = 1;
    cycle();
    #2 check("credit_reopen", addr_valid, 1'b1);
    mon_budget = -1;
    run_to_idle("credit", 200);
    check("credit_total", beats_acc, 8);

    // Random stalls on both streams with random jobs
    ready_pct = 60;
    mon_pct   = 50;
    for (int r = 0; r < 6; r++) begin
      start_job(AW'($urandom), AW'($urandom_range(1, 6)), PW'($urandom_range(1, 3)));
      run_to_idle("random", 400);
    end
    ready_pct = 100;
    mon_pct   = 100;

    // Empty configurations finish immediately without address beats
    start_job(11'h123, 11'd0, 8'd3);
    #2;
    check("empty_len_done", done, 1'b1);
    check("empty_len_busy", busy, 1'b1);
    check("empty_len_valid", addr_valid, 1'b0);
    cycle();
    #2;
    check("empty_len_idle", busy, 1'b0);
    check("empty_len_pulse", done, 1'b0);
    start_job(11'h123, 11'd4, 8'd0);
    run_to_idle("empty_pass", 10);
    check("empty_pass_beats", beats_acc, 0);

    // A start while busy is ignored
    start_job(11'h100, 11'd5, 8'd2);
    for (int i = 0; i < 3; i++) cycle();
    cfg_base = 11'h300;
    cfg_len  = 11'd1;
    cfg_pass = 8'd1;
    cycle(1'b1);
    run_to_idle("restart_ignored", 200);
    check("restart_ignored_beats", beats_acc, 10);

    // Reset in mid-pass, then a clean job
    mon_pct = 50;
    start_job(11'h200, 11'd6, 8'd2);
    for (int i = 0; i < 4; i++) cycle();
    cycle(1'b0, 1'b1);
    check_reset_values("mid_reset");
    mon_pct = 100;
    start_job(11'h055, 11'd2, 8'd1);
    run_to_idle("after_reset", 100);
    check("after_reset_beats", beats_acc, 2);
    #2 check("after_reset_err", err, 1'b0);

    // Stray data beat in IDLE sets the sticky error
    stray = 1;
    cycle();
    stray = 0;
    cycle();
    #2 check("stray_err", err, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    #2 check("stray_err_sticky", err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
